// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU op codes, flag bit positions and arbiter FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;
  typedef logic [3:0] alu_flags_t;

  localparam alu_ctrl_t OP_ADD  = 4'b0000;
  localparam alu_ctrl_t OP_SUB  = 4'b0001;
  localparam alu_ctrl_t OP_EQ   = 4'b0010;
  localparam alu_ctrl_t OP_NEQ  = 4'b0011;
  localparam alu_ctrl_t OP_AND  = 4'b0100;
  localparam alu_ctrl_t OP_OR   = 4'b0101;
  localparam alu_ctrl_t OP_ADDM = 4'b0110;
  localparam alu_ctrl_t OP_XOR  = 4'b0111;
  localparam alu_ctrl_t OP_SLL  = 4'b1000;
  localparam alu_ctrl_t OP_SRL  = 4'b1001;
  localparam alu_ctrl_t OP_SRA  = 4'b1010;
  localparam alu_ctrl_t OP_SLTU = 4'b1100;
  localparam alu_ctrl_t OP_SLT  = 4'b1111;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_CARRY = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_if
// Brief   : One requester's request/response channel pair toward the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int N = 32
);
  import alu_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic [N-1:0]   req_a;
  logic [N-1:0]   req_b;
  alu_ctrl_t      req_ctrl;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_result;
  alu_flags_t     rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin arbiter producing a one-hot grant.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  wire logic [1:0] valid,
  input  wire logic       last_grant,
  output logic      [1:0] grant
);
  // Under contention the port that did not win last time takes the grant.
  assign grant[0] = valid[0] & (~valid[1] |  last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin sharing of one external ALU between two requesters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  alu_arbiter_if.slave      p0,
  alu_arbiter_if.slave      p1,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output alu_ctrl_t         alu_ctrl,
  input  wire logic [N-1:0] alu_result,
  input  wire alu_flags_t   alu_flags
);

  logic [1:0]   r_state;
  logic         r_last_grant;
  logic         r_owner;
  logic [N-1:0] r_op_a;
  logic [N-1:0] r_op_b;
  alu_ctrl_t    r_op_ctrl;
  logic [N-1:0] r_res;
  alu_flags_t   r_flags;

  logic [1:0]   w_grant;
  logic         w_idle;
  logic         w_accept;
  logic         w_rsp_ready;

  rr_arb2 u_arb (
    .valid      ({p1.req_valid, p0.req_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // Ready is held low while reset is asserted even though the FSM sits in IDLE.
  assign w_idle       = (r_state == S_IDLE) && !rst;
  assign w_accept     = w_idle && (w_grant != 2'b00);
  assign p0.req_ready = w_idle & w_grant[0];
  assign p1.req_ready = w_idle & w_grant[1];

  assign p0.rsp_valid  = (r_state == S_RESP) && !r_owner;
  assign p1.rsp_valid  = (r_state == S_RESP) &&  r_owner;
  assign p0.rsp_result = r_res;
  assign p1.rsp_result = r_res;
  assign p0.rsp_flags  = r_flags;
  assign p1.rsp_flags  = r_flags;
  assign w_rsp_ready   = r_owner ? p1.rsp_ready : p0.rsp_ready;

  assign alu_a    = r_op_a;
  assign alu_b    = r_op_b;
  assign alu_ctrl = r_op_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctrl    <= '0;
      r_res        <= '0;
      r_flags      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a       <= w_grant[1] ? p1.req_a    : p0.req_a;
            r_op_b       <= w_grant[1] ? p1.req_b    : p0.req_b;
            r_op_ctrl    <= w_grant[1] ? p1.req_ctrl : p0.req_ctrl;
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= alu_result;
          r_flags <= alu_flags;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
